// File: rtl/cmd_addr_latch_if.sv
// Host-bus bundle for cmd_addr_latch: NAND-style strobes and data in,
// decoded command / assembled address and status pulses out.
interface cmd_addr_latch_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 24
);
   logic              CE;
   logic              CLE;
   logic              ALE;
   logic              WE_n;
   logic [DATA_W-1:0] io_in;
   logic              RB;
   logic [3:0]        command;
   logic              command_ready;
   logic [ADDR_W-1:0] address;
   logic              address_ready;
   logic              cmd_err;

   modport master (
      output CE, CLE, ALE, WE_n, io_in, RB,
      input  command, command_ready, address, address_ready, cmd_err
   );

   modport slave (
      input  CE, CLE, ALE, WE_n, io_in, RB,
      output command, command_ready, address, address_ready, cmd_err
   );
endinterface

// File: rtl/cmd_addr_latch.sv
// Host-bus front end: latches NAND-style command/address cycles on WE_n rising edges.
// Define WE_SYNC_EN to insert a 2-flop synchroniser ahead of the input stage (asynchronous host).
module cmd_addr_latch #(
   parameter int DATA_W      = 8,
   parameter int ADDR_CYCLES = 3,
   parameter int ADDR_W      = DATA_W * ADDR_CYCLES
) (
   input logic             clk,
   input logic             rst_n,
   cmd_addr_latch_if.slave bus
);

   localparam int CNT_W = (ADDR_CYCLES > 1) ? $clog2(ADDR_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(ADDR_CYCLES - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ADDR   = 2'd1;
   localparam logic [1:0] ST_AREADY = 2'd2;

   localparam logic [DATA_W-1:0] OP_WSETUP  = DATA_W'(8'h80);
   localparam logic [DATA_W-1:0] OP_WCONFIRM = DATA_W'(8'h10);
   localparam logic [DATA_W-1:0] OP_RSETUP  = DATA_W'(8'h00);
   localparam logic [DATA_W-1:0] OP_RCONFIRM = DATA_W'(8'h30);
   localparam logic [DATA_W-1:0] OP_RESET   = DATA_W'(8'hFF);

   logic              in_we, in_cle, in_ale, in_ce;
   logic [DATA_W-1:0] in_io;

`ifdef WE_SYNC_EN
   logic [1:0]        sy_we, sy_cle, sy_ale, sy_ce;
   logic [DATA_W-1:0] sy1_io, sy2_io;

   // Idle levels (WE_n/CE high) on reset so release cannot fake a strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sy_we  <= '1;
         sy_ce  <= '1;
         sy_cle <= '0;
         sy_ale <= '0;
         sy1_io <= '0;
         sy2_io <= '0;
      end else begin
         sy_we  <= {sy_we[0], bus.WE_n};
         sy_ce  <= {sy_ce[0], bus.CE};
         sy_cle <= {sy_cle[0], bus.CLE};
         sy_ale <= {sy_ale[0], bus.ALE};
         sy1_io <= bus.io_in;
         sy2_io <= sy1_io;
      end
   end

   assign in_we  = sy_we[1];
   assign in_ce  = sy_ce[1];
   assign in_cle = sy_cle[1];
   assign in_ale = sy_ale[1];
   assign in_io  = sy2_io;
`else
   assign in_we  = bus.WE_n;
   assign in_ce  = bus.CE;
   assign in_cle = bus.CLE;
   assign in_ale = bus.ALE;
   assign in_io  = bus.io_in;
`endif

   logic              s_we, s_we_d, s_cle, s_ale, s_ce;
   logic [DATA_W-1:0] s_io;
   logic              strobe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_we   <= 1'b1;
         s_we_d <= 1'b1;
         s_ce   <= 1'b1;
         s_cle  <= 1'b0;
         s_ale  <= 1'b0;
         s_io   <= '0;
      end else begin
         s_we   <= in_we;
         s_we_d <= s_we;
         s_ce   <= in_ce;
         s_cle  <= in_cle;
         s_ale  <= in_ale;
         s_io   <= in_io;
      end
   end

   assign strobe = s_we & ~s_we_d;

   logic       cmd_ok, cmd_setup, busy_block;
   logic [3:0] cmd_code;

   always_comb begin
      cmd_ok    = 1'b1;
      cmd_setup = 1'b0;
      cmd_code  = '0;
      case (s_io)
         OP_WSETUP:   begin cmd_code = 4'b0100; cmd_setup = 1'b1; end
         OP_WCONFIRM: cmd_code = 4'b0010;
         OP_RSETUP:   begin cmd_code = 4'b0001; cmd_setup = 1'b1; end
         OP_RCONFIRM: cmd_code = 4'b1000;
         OP_RESET:    cmd_code = 4'b1111;
         default:     cmd_ok = 1'b0;
      endcase
   end

   // While busy only a pure command cycle carrying the reset opcode gets through.
   assign busy_block = ~bus.RB & ~(s_cle & ~s_ale & (s_io == OP_RESET));

   logic [1:0]        state;
   logic [CNT_W-1:0]  byte_cnt;
   logic [3:0]        cmd_q;
   logic [ADDR_W-1:0] addr_q;
   logic              cmd_rdy_q, addr_rdy_q, err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         byte_cnt   <= '0;
         cmd_q      <= '0;
         addr_q     <= '0;
         cmd_rdy_q  <= 1'b0;
         addr_rdy_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         cmd_rdy_q <= 1'b0;
         err_q     <= 1'b0;
         if (s_ce) begin
            state      <= ST_IDLE;
            addr_rdy_q <= 1'b0;
            byte_cnt   <= '0;
         end else if (strobe) begin
            if (busy_block || (s_cle && s_ale)) begin
               err_q <= 1'b1;
            end else if (s_cle) begin
               if (cmd_ok) begin
                  cmd_q      <= cmd_code;
                  cmd_rdy_q  <= 1'b1;
                  addr_rdy_q <= 1'b0;
                  byte_cnt   <= '0;
                  state      <= cmd_setup ? ST_ADDR : ST_IDLE;
               end else begin
                  err_q <= 1'b1;
               end
            end else if (s_ale) begin
               if (state == ST_ADDR) begin
                  addr_q[int'(byte_cnt)*DATA_W +: DATA_W] <= s_io;
                  if (byte_cnt == LAST_BYTE) begin
                     addr_rdy_q <= 1'b1;
                     byte_cnt   <= '0;
                     state      <= ST_AREADY;
                  end else begin
                     byte_cnt <= byte_cnt + CNT_W'(1);
                  end
               end else begin
                  err_q <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.command       = cmd_q;
   assign bus.command_ready = cmd_rdy_q;
   assign bus.address       = addr_q;
   assign bus.address_ready = addr_rdy_q;
   assign bus.cmd_err       = err_q;

endmodule

// File: tb/tb_cmd_addr_latch.sv
// Self-checking bench for cmd_addr_latch: directed bus cycles against a transaction-level model.
module tb_cmd_addr_latch;

   localparam int DATA_W      = 8;
   localparam int ADDR_CYCLES = 3;
   localparam int ADDR_W      = DATA_W * ADDR_CYCLES;
`ifdef WE_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   cmd_addr_latch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   cmd_addr_latch #(
      .DATA_W(DATA_W),
      .ADDR_CYCLES(ADDR_CYCLES),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit started = 1'b0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Model: host operations update an abstract view; each result becomes visible LAT edges later.
   typedef struct {
      int                due;
      logic [3:0]        cmd;
      logic [ADDR_W-1:0] addr;
      logic              ar, cr, er;
   } snap_t;
   snap_t q[$];

   logic [3:0]        exp_cmd  = '0;
   logic [ADDR_W-1:0] exp_addr = '0;
   logic              exp_ar = 1'b0, exp_cr = 1'b0, exp_er = 1'b0;

   logic [3:0] m_cmd;
   logic [7:0] m_bytes [ADDR_CYCLES];
   int         m_nbytes;
   bit         m_collect, m_full, m_ce_off;

   function automatic logic [ADDR_W-1:0] m_address();
      logic [ADDR_W-1:0] a = '0;
      for (int i = 0; i < ADDR_CYCLES; i++) a = a | (ADDR_W'(m_bytes[i]) << (8 * i));
      return a;
   endfunction

   function automatic int code_of(input logic [7:0] d);
      case (d)
         8'h80:   return 4;
         8'h10:   return 2;
         8'h00:   return 1;
         8'h30:   return 8;
         8'hFF:   return 15;
         default: return -1;
      endcase
   endfunction

   function automatic void push(input bit cr, input bit er);
      snap_t s;
      s.due  = cyc + LAT;
      s.cmd  = m_cmd;
      s.addr = m_address();
      s.ar   = m_full;
      s.cr   = cr;
      s.er   = er;
      q.push_back(s);
   endfunction

   function automatic void model_reset();
      q.delete();
      m_cmd = '0;
      for (int i = 0; i < ADDR_CYCLES; i++) m_bytes[i] = '0;
      m_nbytes = 0; m_collect = 0; m_full = 0; m_ce_off = 0;
      exp_cmd = '0; exp_addr = '0; exp_ar = 0; exp_cr = 0; exp_er = 0;
   endfunction

   function automatic void model_op(input bit cle, input bit ale, input logic [7:0] d);
      int c;
      if (m_ce_off) return;
      if ((!bus.RB && !(cle && !ale && d == 8'hFF)) || (cle && ale)) begin
         push(0, 1);
      end else if (cle) begin
         c = code_of(d);
         if (c < 0) begin
            push(0, 1);
         end else begin
            m_cmd = c[3:0];
            m_full = 0;
            m_nbytes = 0;
            m_collect = (d == 8'h80) || (d == 8'h00);
            push(1, 0);
         end
      end else if (ale) begin
         if (!m_collect) begin
            push(0, 1);
         end else begin
            m_bytes[m_nbytes] = d;
            m_nbytes++;
            if (m_nbytes == ADDR_CYCLES) begin
               m_full = 1; m_collect = 0; m_nbytes = 0;
            end
            push(0, 0);
         end
      end
   endfunction

   always @(posedge clk) begin
      cyc++;
      exp_cr = 1'b0;
      exp_er = 1'b0;
      while (q.size() > 0 && q[0].due <= cyc) begin
         exp_cmd  = q[0].cmd;
         exp_addr = q[0].addr;
         exp_ar   = q[0].ar;
         exp_cr   = q[0].cr;
         exp_er   = q[0].er;
         void'(q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("command", bus.command, exp_cmd);
         chk("command_ready", bus.command_ready, exp_cr);
         chk("address", bus.address, exp_addr);
         chk("address_ready", bus.address_ready, exp_ar);
         chk("cmd_err", bus.cmd_err, exp_er);
         chk("ready_err_excl", bus.command_ready & bus.cmd_err, 0);
      end
   end

   task automatic bus_op(input bit cle, input bit ale, input logic [7:0] d);
      @(posedge clk); #1;
      bus.CLE = cle; bus.ALE = ale; bus.io_in = d; bus.WE_n = 1'b0;
      @(posedge clk); #1;
      bus.WE_n = 1'b1;
      model_op(cle, ale, d);
      @(posedge clk); #1;
      bus.CLE = 1'b0; bus.ALE = 1'b0;
      repeat (LAT + 1) @(posedge clk);
      #1;
   endtask

   task automatic set_ce(input bit v);
      @(posedge clk); #1;
      bus.CE = v;
      if (v) begin
         m_collect = 0; m_nbytes = 0; m_full = 0;
         push(0, 0);
      end
      m_ce_off = v;
      repeat (LAT + 1) @(posedge clk);
      #1;
   endtask

   task automatic set_rb(input bit v);
      @(posedge clk); #1;
      bus.RB = v;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_command"}, bus.command, 0);
      chk({tag, "_command_ready"}, bus.command_ready, 0);
      chk({tag, "_address"}, bus.address, 0);
      chk({tag, "_address_ready"}, bus.address_ready, 0);
      chk({tag, "_cmd_err"}, bus.cmd_err, 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_zero("async_rst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.CE = 1'b0; bus.CLE = 1'b0; bus.ALE = 1'b0; bus.WE_n = 1'b1;
      bus.io_in = '0; bus.RB = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      started = 1'b1;
      repeat (2) @(posedge clk);

      // Write setup and 3-byte address
      bus_op(1, 0, 8'h80);
      chk("lit_wsetup_cmd", bus.command, 4'b0100);
      bus_op(0, 1, 8'h12);
      bus_op(0, 1, 8'h34);
      chk("lit_partial_ready", bus.address_ready, 0);
      bus_op(0, 1, 8'h56);
      chk("lit_addr", bus.address, 24'h563412);
      chk("lit_model_addr", exp_addr, 24'h563412);
      chk("lit_addr_ready", bus.address_ready, 1);
      chk("lit_model_ready", exp_ar, 1);

      // 4th byte rejected, address kept
      bus_op(0, 1, 8'h78);
      chk("lit_4th_addr", bus.address, 24'h563412);

      // Write confirm
      bus_op(1, 0, 8'h10);
      chk("lit_wconfirm_cmd", bus.command, 4'b0010);
      chk("lit_wconfirm_ready", bus.address_ready, 0);

      // Error cases and a silent data cycle
      bus_op(1, 0, 8'h5A);
      chk("lit_bad_cmd", bus.command, 4'b0010);
      bus_op(0, 1, 8'h99);
      chk("lit_idle_ale", bus.address, 24'h563412);
      bus_op(1, 1, 8'h80);
      chk("lit_cle_ale", bus.command, 4'b0010);
      bus_op(0, 0, 8'hEE);

      // Busy
      set_rb(0);
      bus_op(1, 0, 8'h80);
      chk("lit_busy_cmd", bus.command, 4'b0010);
      bus_op(1, 0, 8'hFF);
      chk("lit_busy_reset", bus.command, 4'b1111);
      chk("lit_model_busy_reset", exp_cmd, 4'b1111);
      set_rb(1);

      // Read setup, CE abort after 2 bytes
      bus_op(1, 0, 8'h00);
      chk("lit_rsetup_cmd", bus.command, 4'b0001);
      bus_op(0, 1, 8'hA1);
      bus_op(0, 1, 8'hB2);
      chk("lit_partial_addr", bus.address, 24'h56B2A1);
      set_ce(1);
      chk("lit_ce_ready", bus.address_ready, 0);
      bus_op(1, 0, 8'h30);
      chk("lit_ce_ignored", bus.command, 4'b0001);
      set_ce(0);

      // Clean write setup after abort
      bus_op(1, 0, 8'h80);
      bus_op(0, 1, 8'hD0);
      bus_op(0, 1, 8'hE0);
      bus_op(0, 1, 8'hF0);
      chk("lit_after_abort_addr", bus.address, 24'hF0E0D0);
      chk("lit_after_abort_ready", bus.address_ready, 1);

      // Setup command from full-address state, then read confirm
      bus_op(1, 0, 8'h00);
      chk("lit_aready_setup", bus.address_ready, 0);
      bus_op(1, 0, 8'h30);
      chk("lit_rconfirm_cmd", bus.command, 4'b1000);

      // Reset mid-address
      bus_op(1, 0, 8'h80);
      bus_op(0, 1, 8'h11);
      chk("lit_mid_byte", bus.address, 24'hF0E011);
      do_reset();
      chk("lit_post_rst_addr", bus.address, 0);
      bus_op(0, 1, 8'h22);
      chk("lit_post_rst_idle", bus.address, 0);

      repeat (4) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
